// File: rtl/gather_sched.sv
// gather_sched: gather-test sequencer for the 4-node bidirectional ring (nodes 0..3).
// Optional build macro GATHER_SHORTCUT_EN routes distance-3 packets the short way (dir 1, one hop).
module gather_sched #(
  parameter int NUM_TESTS = 7,
  parameter int TIMEOUT   = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         polarity,
  input  logic [3:0]   peri,
  output logic [3:0]   pesi,
  output logic [255:0] pedi,
  input  logic [3:0]   peso,
  input  logic [255:0] pedo,
  output logic [3:0]   pero,
  output logic         busy,
  output logic         done,
  output logic [1:0]   phase_o,
  output logic         lat_vld,
  output logic [15:0]  lat_o,
  output logic [7:0]   err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INJECT = 2'd1,
    NEXT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [15:0]  test;
  logic [1:0]   phase;
  logic [3:0]   sent_mask;
  logic [3:0]   rcv_mask;
  logic [9:0]   timer;
  logic [15:0]  last_lat;

  logic [3:0]   exp_mask;
  logic [3:0]   fire;
  logic [3:0]   rcv_set;
  logic         all_rcv;
  logic         timeout_hit;
  logic         last_phase;
  logic         in_run;
  logic [2:0]   err_add;
  logic [9:0]   err_sum;
  logic [255:0] pedi_nxt;
  logic [31:0]  exp_payload;
  logic [15:0]  src;
  logic [31:0]  pay;

  function automatic logic [63:0] build_pkt(input logic [1:0] s, input logic [1:0] p,
                                            input logic [15:0] t);
    logic [1:0] d;
    logic       dir;
    logic [7:0] hop;
    d   = p - s;
    dir = 1'b0;
    hop = 8'h01;
    case (d)
      2'd1: begin
        dir = 1'b0;
        hop = 8'h01;
      end
      2'd2: begin
        dir = 1'b0;
        hop = 8'h03;
      end
      2'd3: begin
`ifdef GATHER_SHORTCUT_EN
        dir = 1'b1;
        hop = 8'h01;
`else
        dir = 1'b0;
        hop = 8'h07;
`endif
      end
      default: begin
        dir = 1'b0;
        hop = 8'h01;
      end
    endcase
    return {1'b0, dir, 6'b0, hop, 14'b0, s, t, 14'b0, p};
  endfunction

  assign exp_mask    = ~(4'b0001 << phase);
  assign all_rcv     = (rcv_mask == exp_mask);
  assign timeout_hit = (state == INJECT) && !all_rcv && (timer == 10'(TIMEOUT));
  assign last_phase  = (phase == 2'd3) && (test == 16'(NUM_TESTS - 1));
  assign in_run      = (state == INJECT) || (state == NEXT);
  assign exp_payload = {test, 14'b0, phase};
  assign phase_o     = phase;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pero      = 4'h0;
    case (state)
      IDLE: begin
        if (start) state_nxt = INJECT;
      end
      INJECT: begin
        busy = 1'b1;
        pero = 4'hF;
        if (all_rcv || timeout_hit) state_nxt = NEXT;
      end
      NEXT: begin
        busy      = 1'b1;
        pero      = 4'hF;
        state_nxt = last_phase ? DONE : INJECT;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A node injects only when its ring polarity group is active; nothing is issued on the exit cycle.
  always_comb begin
    fire     = '0;
    pedi_nxt = '0;
    for (int s = 0; s < 4; s++) begin
      if ((state == INJECT) && (state_nxt == INJECT) && (2'(s) != phase) && !sent_mask[s] &&
          peri[s] && (polarity == (s >= 2))) begin
        fire[s]               = 1'b1;
        pedi_nxt[64*s +: 64]  = build_pkt(2'(s), phase, test);
      end
    end
  end

  // Only the current destination can accept a good packet, so at most one source bit is set per cycle.
  always_comb begin
    rcv_set = '0;
    err_add = '0;
    src     = '0;
    pay     = '0;
    for (int n = 0; n < 4; n++) begin
      src = pedo[64*n+32 +: 16];
      pay = pedo[64*n +: 32];
      if (in_run && peso[n]) begin
        if ((2'(n) == phase) && (src[15:2] == 14'd0) && (src[1:0] != phase) &&
            !rcv_mask[src[1:0]] && (pay == exp_payload)) begin
          rcv_set[src[1:0]] = 1'b1;
        end else begin
          err_add = err_add + 3'd1;
        end
      end
    end
    err_sum = {2'b0, err_cnt} + {7'b0, err_add} + {9'b0, timeout_hit};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      test      <= '0;
      phase     <= '0;
      sent_mask <= '0;
      rcv_mask  <= '0;
      timer     <= '0;
      last_lat  <= '0;
      pesi      <= '0;
      pedi      <= '0;
      lat_vld   <= 1'b0;
      lat_o     <= '0;
      err_cnt   <= '0;
    end else begin
      pesi    <= fire;
      pedi    <= pedi_nxt;
      lat_vld <= 1'b0;
      if (in_run) err_cnt <= (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
      case (state)
        IDLE: begin
          if (start) begin
            test      <= '0;
            phase     <= '0;
            sent_mask <= '0;
            rcv_mask  <= '0;
            timer     <= '0;
            last_lat  <= '0;
            lat_o     <= '0;
            err_cnt   <= '0;
          end
        end
        INJECT: begin
          timer     <= timer + 10'd1;
          sent_mask <= sent_mask | fire;
          rcv_mask  <= rcv_mask | rcv_set;
          if (|rcv_set) last_lat <= {6'b0, timer};
          if (state_nxt == NEXT) begin
            lat_vld <= 1'b1;
            lat_o   <= timeout_hit ? 16'hFFFF : last_lat;
          end
        end
        NEXT: begin
          sent_mask <= '0;
          rcv_mask  <= '0;
          timer     <= '0;
          last_lat  <= '0;
          // The final phase/test are left in place so phase_o shows where the run ended.
          if (!last_phase) begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) test <= test + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gather_sched.sv
// tb_gather_sched: scoreboard bench for gather_sched with a ring model that echoes each
// injection to its destination node after a fixed delay.
module tb_gather_sched;

  localparam int NUM_TESTS  = 7;
  localparam int TIMEOUT    = 1023;
  localparam int RING_DELAY = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         polarity = 1'b0;
  logic [3:0]   peri = 4'hF;
  logic [3:0]   pesi;
  logic [255:0] pedi;
  logic [3:0]   peso = '0;
  logic [255:0] pedo = '0;
  logic [3:0]   pero;
  logic         busy;
  logic         done;
  logic [1:0]   phase_o;
  logic         lat_vld;
  logic [15:0]  lat_o;
  logic [7:0]   err_cnt;

  gather_sched #(.NUM_TESTS(NUM_TESTS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .polarity(polarity), .peri(peri),
    .pesi(pesi), .pedi(pedi), .peso(peso), .pedo(pedo), .pero(pero), .busy(busy),
    .done(done), .phase_o(phase_o), .lat_vld(lat_vld), .lat_o(lat_o), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int phase;
    int test;
    bit timeout;
    int err;
  } lat_exp_t;

  typedef struct {
    int          due;
    int          node;
    logic [63:0] pkt;
  } dlv_t;

  lat_exp_t lat_q[$];
  dlv_t     dlv_q[$];
  lat_exp_t cur;
  int       node_free[4];
  int       cyc = 0;
  int       checks = 0;
  int       fails = 0;
  int       final_err = 0;
  int       ref_cyc = 0;
  int       drop_phase = -1;
  int       drop_src = -1;
  bit       hold3 = 0;
  bit       dup_en = 0;
  bit       pol_hold = 0;
  bit       first_pesi_pending = 0;
  bit       next_phase_pending = 0;
  bit       done_seen = 0;
  bit       tb_active = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mk_pkt(input int s, input int p, input int t);
    int         d;
    logic       dir;
    logic [7:0] hop;
    d   = (p - s + 4) % 4;
    dir = 1'b0;
    hop = 8'h00;
    if (d == 1) hop = 8'h01;
    else if (d == 2) hop = 8'h03;
    else if (d == 3) begin
`ifdef GATHER_SHORTCUT_EN
      dir = 1'b1;
      hop = 8'h01;
`else
      hop = 8'h07;
`endif
    end
    return {1'b0, dir, 6'b0, hop, 16'(s), 16'(t), 14'b0, 2'(p)};
  endfunction

  task automatic schedule(input int node, input logic [63:0] pkt);
    dlv_t e;
    e.due = cyc + RING_DELAY;
    if (node_free[node] > e.due) e.due = node_free[node];
    node_free[node] = e.due + 1;
    e.node = node;
    e.pkt  = pkt;
    dlv_q.push_back(e);
  endtask

  // Monitor and ring model: sample just after the edge, then drive the next cycle's inputs.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (tb_active) begin
        for (int s = 0; s < 4; s++) begin
          if (pesi[s]) begin
            if (lat_q.size() == 0) begin
              checkOutput("pesi_unexpected", 64'(pesi[s]), 64'd0);
            end else begin
              cur = lat_q[0];
              checkOutput("pedi", pedi[64*s +: 64], mk_pkt(s, cur.phase, cur.test));
              if (!(s == drop_src && cur.phase == drop_phase && cur.test == 0))
                schedule(cur.phase, pedi[64*s +: 64]);
              if (dup_en && s == 1 && cur.phase == 0 && cur.test == 0) begin
                schedule(0, pedi[64*s +: 64]);
                schedule(3, pedi[64*s +: 64]);
              end
            end
          end else begin
            checkOutput("pedi_idle", pedi[64*s +: 64], 64'd0);
          end
        end
        if (first_pesi_pending && pesi != 4'h0) begin
          checkOutput("first_pesi", 64'(pesi), 64'h2);
          first_pesi_pending = 0;
        end
        if (lat_q.size() > 0) begin
          checkOutput("pesi_self", 64'(pesi[lat_q[0].phase]), 64'd0);
          if (hold3 && lat_q[0].phase == 0 && lat_q[0].test == 0)
            checkOutput("pesi3_held", 64'(pesi[3]), 64'd0);
        end
        checkOutput("pero", 64'(pero), busy ? 64'hF : 64'h0);
        if (lat_vld) begin
          if (lat_q.size() == 0) begin
            checkOutput("lat_unexpected", 64'(lat_vld), 64'd0);
          end else begin
            cur = lat_q.pop_front();
            checkOutput("phase_o", 64'(phase_o), 64'(cur.phase));
            if (cur.timeout) begin
              checkOutput("lat_timeout", 64'(lat_o), 64'hFFFF);
              checkOutput("timeout_len",
                          64'((cyc - ref_cyc >= TIMEOUT) && (cyc - ref_cyc <= TIMEOUT + 4)), 64'd1);
            end else begin
              checkOutput("lat_range", 64'((lat_o >= 16'(RING_DELAY)) && (lat_o < 16'd64)), 64'd1);
            end
            if (cur.err >= 0) checkOutput("err_cnt", 64'(err_cnt), 64'(cur.err));
            next_phase_pending = (lat_q.size() > 0);
          end
          ref_cyc = cyc;
        end else if (next_phase_pending) begin
          checkOutput("phase_next", 64'(phase_o), 64'(lat_q[0].phase));
          next_phase_pending = 0;
        end
        if (done) begin
          checkOutput("err_final", 64'(err_cnt), 64'(final_err));
          checkOutput("busy_in_done", 64'(busy), 64'd0);
          checkOutput("lat_q_left", 64'(lat_q.size()), 64'd0);
          done_seen = 1;
        end
      end
      peso = '0;
      pedo = '0;
      for (int i = dlv_q.size() - 1; i >= 0; i--) begin
        if (dlv_q[i].due == cyc) begin
          peso[dlv_q[i].node]            = 1'b1;
          pedo[64*dlv_q[i].node +: 64]   = dlv_q[i].pkt;
          dlv_q.delete(i);
        end
      end
      polarity = pol_hold ? 1'b0 : ~polarity;
      if (hold3 && lat_q.size() > 0 && lat_q[0].phase == 0 && lat_q[0].test == 0) peri = 4'b0111;
      else peri = 4'hF;
    end
  end

  // Sets up one run: knobs, expected per-phase results, then a start pulse.
  task automatic applyStimulus(input bit hold_pol, input int d_phase, input int d_src,
                               input bit h3, input bit dup);
    lat_exp_t e;
    @(posedge clk);
    #2;
    pol_hold           = hold_pol;
    first_pesi_pending = hold_pol;
    drop_phase         = d_phase;
    drop_src           = d_src;
    hold3              = h3;
    dup_en             = dup;
    done_seen          = 0;
    final_err          = (d_phase >= 0 || h3) ? 1 : (dup ? 2 : 0);
    for (int t = 0; t < NUM_TESTS; t++) begin
      for (int p = 0; p < 4; p++) begin
        e.phase   = p;
        e.test    = t;
        e.timeout = (t == 0) && ((p == d_phase) || (h3 && p == 0));
        e.err     = 0;
        if (d_phase >= 0 && (t > 0 || p >= d_phase)) e.err = 1;
        if (h3) e.err = 1;
        if (dup) e.err = (t == 0 && p == 0) ? -1 : 2;
        lat_q.push_back(e);
      end
    end
    @(posedge clk);
    #2;
    start   = 1'b1;
    ref_cyc = cyc;
    @(posedge clk);
    #2;
    start = 1'b0;
    if (hold_pol) begin
      repeat (6) @(posedge clk);
      #2;
      pol_hold = 0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!done_seen) checkOutput("done_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #2;
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_pesi", 64'(pesi), 64'd0);
    checkOutput("rst_pedi", 64'(|pedi), 64'd0);
    checkOutput("rst_pero", 64'(pero), 64'd0);
    checkOutput("rst_lat_vld", 64'(lat_vld), 64'd0);
    checkOutput("rst_lat_o", 64'(lat_o), 64'd0);
    checkOutput("rst_err", 64'(err_cnt), 64'd0);
    checkOutput("rst_phase", 64'(phase_o), 64'd0);
    tb_active = 1;

    $display("[TB] clean run, polarity held low at start");
    applyStimulus(1, -1, -1, 0, 0);
    wait_done(3000);

    $display("[TB] drop node2 packet in phase 1");
    applyStimulus(0, 1, 2, 0, 0);
    wait_done(5000);

    $display("[TB] duplicate source and stray arrival in phase 0");
    applyStimulus(0, -1, -1, 0, 1);
    wait_done(3000);

    $display("[TB] node3 not ready through phase 0");
    applyStimulus(0, -1, -1, 1, 0);
    wait_done(5000);

    $display("[TB] reset in the middle of phase 2");
    applyStimulus(0, -1, -1, 0, 0);
    n = 0;
    while (lat_q.size() > 26 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_phase2", 64'(lat_q.size() <= 26), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_pesi", 64'(pesi), 64'd0);
    checkOutput("mid_rst_err", 64'(err_cnt), 64'd0);
    checkOutput("mid_rst_lat_vld", 64'(lat_vld), 64'd0);
    checkOutput("mid_rst_phase", 64'(phase_o), 64'd0);
    lat_q.delete();
    dlv_q.delete();
    peso = '0;
    pedo = '0;
    for (int i = 0; i < 4; i++) node_free[i] = 0;
    next_phase_pending = 0;
    repeat (2) @(posedge clk);
    applyStimulus(0, -1, -1, 0, 0);
    wait_done(3000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
